// File: rtl/jtag_pkg.sv
// Shared JTAG register constants: IR width, opcodes and the DR selection decode.
package jtag_pkg;

    localparam int IR_W = 4;

    localparam logic [IR_W-1:0] IR_IDCODE  = 4'b0001;
    localparam logic [IR_W-1:0] IR_USER    = 4'b0010;
    localparam logic [IR_W-1:0] IR_BYPASS  = 4'b1111;
    localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0001;

    typedef enum logic [1:0] {
        DR_IDCODE,
        DR_USER,
        DR_BYPASS
    } dr_sel_e;

    // Unknown opcodes, and USER when that register is not built, fall back to BYPASS.
    function automatic dr_sel_e decode_ir(input logic [IR_W-1:0] ir, input logic user_en);
        dr_sel_e sel;
        sel = DR_BYPASS;
        if (ir == IR_IDCODE)
            sel = DR_IDCODE;
        else if (ir == IR_USER && user_en)
            sel = DR_USER;
        return sel;
    endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// Generic capture/shift register: parallel load on capture, right shift with tdi into the MSB.
module jtag_shift_reg #(
    parameter int W = 4
) (
    input  logic         tck,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         capture,
    input  logic         shift,
    input  logic [W-1:0] load,
    input  logic         tdi,
    output logic [W-1:0] q,
    output logic         so
);

    // NOTE: reset is synchronous, so it is simply the highest-priority branch inside the clocked block.
    always_ff @(posedge tck) begin
        if (!reset_n || clear)
            q <= '0;
        else if (capture)
            q <= load;
        else if (shift)
            // NOTE: non-blocking so every flop in the chain samples its neighbour's pre-edge value.
            q <= (q >> 1) | (W'(tdi) << (W - 1));
    end

    assign so = q[0];

endmodule

// File: rtl/jtag_regs.sv
// JTAG instruction and data registers (IR, IDCODE, BYPASS, optional USER).
// Optional USER data register is built only when JTAG_USER_DR_EN is defined.
module jtag_regs
    import jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE_VAL = 32'h0A5C_3001,
    parameter int          USER_W     = 8
) (
    input  logic              tck,
    input  logic              reset_n,
    input  logic              tap_reset,
    input  logic              capture_ir,
    input  logic              shift_ir,
    input  logic              update_ir,
    input  logic              capture_dr,
    input  logic              shift_dr,
    input  logic              update_dr,
    input  logic              select,
    input  logic              enable,
    input  logic              tdi,
    input  logic [USER_W-1:0] user_status,
    output logic              tdo,
    output logic              tdo_oe,
    output logic [IR_W-1:0]   ir_active,
    output logic [USER_W-1:0] user_data,
    output logic              user_valid
);

    // Capture beats shift; update is dropped if either is present; tap_reset kills everything.
    logic ir_cap, ir_sft, ir_upd;
    logic dr_cap, dr_sft, dr_upd;

    assign ir_cap = capture_ir & ~tap_reset;
    assign ir_sft = shift_ir & ~capture_ir & ~tap_reset;
    assign ir_upd = update_ir & ~capture_ir & ~shift_ir & ~tap_reset;
    assign dr_cap = capture_dr & ~tap_reset;
    assign dr_sft = shift_dr & ~capture_dr & ~tap_reset;
    assign dr_upd = update_dr & ~capture_dr & ~shift_dr & ~tap_reset;

    logic [IR_W-1:0] ir_q;
    logic            ir_so;

    jtag_shift_reg #(.W(IR_W)) u_ir (
        .tck     (tck),
        .reset_n (reset_n),
        .clear   (tap_reset),
        .capture (ir_cap),
        .shift   (ir_sft),
        .load    (IR_CAPTURE),
        .tdi     (tdi),
        .q       (ir_q),
        .so      (ir_so)
    );

    always_ff @(posedge tck) begin
        if (!reset_n || tap_reset)
            ir_active <= IR_IDCODE;
        else if (ir_upd)
            ir_active <= ir_q;
    end

    logic    user_so;
    dr_sel_e dr_sel;

`ifdef JTAG_USER_DR_EN
    localparam bit USER_EN = 1'b1;

    logic [USER_W-1:0] user_q;

    jtag_shift_reg #(.W(USER_W)) u_user (
        .tck     (tck),
        .reset_n (reset_n),
        .clear   (tap_reset),
        .capture (dr_cap && dr_sel == DR_USER),
        .shift   (dr_sft && dr_sel == DR_USER),
        .load    (user_status),
        .tdi     (tdi),
        .q       (user_q),
        .so      (user_so)
    );

    always_ff @(posedge tck) begin
        if (!reset_n) begin
            user_data  <= '0;
            user_valid <= 1'b0;
        end else begin
            user_valid <= dr_upd && dr_sel == DR_USER;
            if (dr_upd && dr_sel == DR_USER)
                user_data <= user_q;
        end
    end
`else
    localparam bit USER_EN = 1'b0;

    logic unused_status;

    assign unused_status = ^user_status;
    assign user_so       = 1'b0;
    assign user_data     = '0;
    assign user_valid    = 1'b0;
`endif

    assign dr_sel = decode_ir(ir_active, USER_EN);

    logic [31:0] idcode_unused;
    logic        idcode_so;

    jtag_shift_reg #(.W(32)) u_idcode (
        .tck     (tck),
        .reset_n (reset_n),
        .clear   (tap_reset),
        .capture (dr_cap && dr_sel == DR_IDCODE),
        .shift   (dr_sft && dr_sel == DR_IDCODE),
        .load    (IDCODE_VAL),
        .tdi     (tdi),
        .q       (idcode_unused),
        .so      (idcode_so)
    );

    logic bypass_q;

    always_ff @(posedge tck) begin
        if (!reset_n || tap_reset)
            bypass_q <= 1'b0;
        else if (dr_cap && dr_sel == DR_BYPASS)
            bypass_q <= 1'b0;
        else if (dr_sft && dr_sel == DR_BYPASS)
            bypass_q <= tdi;
    end

    logic dr_tdo;

    always_comb begin
        dr_tdo = idcode_so;
        case (dr_sel)
            DR_USER:   dr_tdo = user_so;
            DR_BYPASS: dr_tdo = bypass_q;
            default:   dr_tdo = idcode_so;
        endcase
        tdo = (select ? ir_so : dr_tdo) & enable;
    end

    assign tdo_oe = enable;

endmodule
